serial_word_rx: RTL
===================

# serial_word_rx

Receive side of the serial link. It deserializes framed 32-bit words from a bit-strobe PHY interface, checks even parity, and buffers good words in a small FIFO. It then drains them as OBI write requests into the downstream double-access mailbox writer port. Bad or overflowing frames are dropped and flagged with single-cycle status pulses.

## Interface
Parameters:
- DATA_WIDTH, 32, payload word width; fixed at 32.
- ADDR_WIDTH, 32, OBI address width.
- TARGET_ADDR, 32'h0, constant address driven on every write.
- FIFO_DEPTH, 2, word buffer depth; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- sdi_valid_i  in  1  a serial bit is presented this cycle.
- sdi_i  in  1  serial bit value; sampled only when sdi_valid_i=1.
- writer_req_o  out  1  OBI request.
- writer_gnt_i  in  1  OBI grant.
- writer_addr_o  out  ADDR_WIDTH  always TARGET_ADDR.
- writer_we_o  out  1  always 1.
- writer_be_o  out  4  always 4'hF.
- writer_wdata_o  out  DATA_WIDTH  FIFO head word.
- busy_o  out  1  a frame is in progress (FSM not IDLE).
- parity_err_o  out  1  one-cycle pulse: frame dropped on parity failure.
- overflow_o  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

## Operation
- Frame format, one bit per sdi_valid_i cycle: start bit (1), then 32 data bits LSB first, then 1 even-parity bit. The XOR of the 32 data bits and the parity bit must be 0.
- Cycles with sdi_valid_i=0 are ignored in every state. There is no timeout.
- RX FSM:
  - IDLE: a valid bit with sdi_i=1 moves to DATA and clears bit_cnt. A valid bit with sdi_i=0 stays in IDLE.
  - DATA: each valid bit shifts into a 32-bit shift register at the MSB, then the register shifts right. bit_cnt (5 bits) increments. The valid bit at bit_cnt=31 moves to PARITY.
  - PARITY: the next valid bit is checked and the FSM returns to IDLE. On pass, the word is pushed. On fail, parity_err_o pulses and nothing is pushed.
- Push rules:
  - The word is accepted if the FIFO is not full, or if it is full but a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow_o pulses.
  - A parity failure never raises overflow_o.
- FIFO: circular, with read/write pointers of log2(FIFO_DEPTH) bits plus a count. Pointers wrap modulo FIFO_DEPTH.
- OBI side:
  - writer_req_o = FIFO not empty. writer_wdata_o = head entry.
  - A transfer completes on writer_req_o && writer_gnt_i; the head is popped at that clock edge.
  - Addr, we, be and wdata stay stable while req is high and not granted.
  - A grant while req=0 is ignored.
  - No response phase is tracked; rvalid is not used.
- Reset (async, any time, including mid-frame or mid-request):
  - FSM returns to IDLE; bit_cnt, shift register and FIFO are cleared.
  - Reset values: writer_req_o=0, writer_wdata_o=0, writer_addr_o=TARGET_ADDR, writer_we_o=1, writer_be_o=4'hF, busy_o=0, parity_err_o=0, overflow_o=0.

## Timing
- A full frame takes 34 valid cycles. Back-to-back frames need no idle gap: a start bit may follow the parity bit on the next valid cycle.
- Parity bit sampled at edge t:
  - Word is visible in the FIFO from cycle t+1.
  - If the FIFO was empty, writer_req_o=1 and writer_wdata_o=word in cycle t+1.
  - parity_err_o or overflow_o is high in cycle t+1 only.
- Grant in cycle c with more than one entry: the next word is on writer_wdata_o in c+1 with req still 1. With one entry, req=0 in c+1.
- Throughput: one word per cycle on the OBI side when gnt is held high.
- busy_o rises in the cycle after the start bit and falls in the cycle after the parity bit.

## Test plan
- Single frame 0xDEADBEEF, parity 0, gnt tied high -> req=1 one cycle after the parity bit with wdata=0xDEADBEEF, addr=TARGET_ADDR, be=4'hF; req=0 the following cycle.
- Frame 0x00000001 with parity 0 (wrong) -> parity_err_o single pulse; req stays 0; next frame 0x00000001 with parity 1 is delivered normally.
- gnt held low, three good frames 0x11111111, 0x22222222, 0x33333333 with FIFO_DEPTH=2 -> third frame raises overflow_o once. Then gnt=1 yields 0x11111111 and 0x22222222 in consecutive cycles, then req=0.
- FIFO full while the third frame's parity bit coincides with a grant -> no overflow_o; output order 0x11111111, 0x22222222, 0x33333333.
- Leading zero valid bits, and sdi_valid_i gaps inserted mid-frame -> same delivered word as a gap-free frame; busy_o stays high across the gaps.
- Assert rst_ni low after 10 data bits and while req is pending -> all outputs at reset values immediately. After release, a fresh frame 0xA5A5A5A5 with parity 0 is delivered intact.

Source files
------------

// File: rtl/serial_word_rx.sv
// serial_word_rx: deserializes start/32-bit/even-parity frames from a
// bit-strobe PHY, buffers good words in a small FIFO and drains them as OBI
// writes to a fixed mailbox address.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   sdi_valid_i, sdi_i serial bit strobe and value
//   writer_*           OBI write request channel (req/gnt/addr/we/be/wdata)
//   busy_o             a frame is being received
//   parity_err_o       one-cycle pulse, frame dropped on parity failure
//   overflow_o         one-cycle pulse, good frame dropped, FIFO full

module serial_word_rx #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  TARGET_ADDR = '0,
    parameter int unsigned            FIFO_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sdi_valid_i,
    input  logic                  sdi_i,
    output logic                  writer_req_o,
    input  logic                  writer_gnt_i,
    output logic [ADDR_WIDTH-1:0] writer_addr_o,
    output logic                  writer_we_o,
    output logic [3:0]            writer_be_o,
    output logic [DATA_WIDTH-1:0] writer_wdata_o,
    output logic                  busy_o,
    output logic                  parity_err_o,
    output logic                  overflow_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [4:0]  LAST_BIT = 5'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic                  ovf_q, ovf_d;
    logic                  frame_ok;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full, empty;
    logic                  push, pop;

    // ---------------- RX FSM ----------------

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = 1'b0;
        frame_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sdi_valid_i && sdi_i) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sdi_valid_i) begin
                    // LSB-first: after all bits the first one sits at bit 0
                    shift_d   = {sdi_i, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sdi_valid_i) begin
                    state_d = IDLE;
                    if ((^shift_q) ^ sdi_i) begin
                        perr_d = 1'b1;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- FIFO ----------------

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = writer_req_o && writer_gnt_i;

    // A full FIFO still takes the word when the head leaves this cycle.
    assign push  = frame_ok && (!full || pop);
    assign ovf_d = frame_ok && full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- outputs ----------------

    assign writer_req_o   = !empty;
    assign writer_wdata_o = mem_q[rptr_q];
    assign writer_addr_o  = TARGET_ADDR;
    assign writer_we_o    = 1'b1;
    assign writer_be_o    = 4'hF;
    assign busy_o         = (state_q != IDLE);
    assign parity_err_o   = perr_q;
    assign overflow_o     = ovf_q;

endmodule
